// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmitter and receiver:
//   tx_state_t  - frame state machine encoding (IDLE, START, DATA, PARITY, STOP)
//   BAUD_CNT_W  - width of the per-bit cycle counter
//   DATA_BITS   - payload bits per frame
//   calc_parity - parity of a data byte (XOR of all data bits)
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int BAUD_CNT_W = 16;
    localparam int DATA_BITS  = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    // Parity bit as sent on the wire; the receiver recomputes it the same way.
    function automatic logic calc_parity(input logic [DATA_BITS-1:0] data_byte);
        return ^data_byte;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_baud_tick
// Counts clk cycles 0..CYCLES_PER_BIT-1 while run is high and wraps to 0.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   clear     - force the counter to 0 (takes priority over run)
//   run       - count enable; when low the counter is held at 0
//   tick      - terminal count: high in the last cycle of each bit period
//   count     - current position inside the bit period
// -----------------------------------------------------------------------------
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int unsigned CYCLES_PER_BIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  run,
    output logic                  tick,
    output logic [BAUD_CNT_W-1:0] count
);

    localparam logic [BAUD_CNT_W-1:0] CNT_LAST = BAUD_CNT_W'(CYCLES_PER_BIT - 1);
    localparam logic [BAUD_CNT_W-1:0] CNT_ZERO = {BAUD_CNT_W{1'b0}};
    localparam logic [BAUD_CNT_W-1:0] CNT_ONE  = BAUD_CNT_W'(1);

    logic [BAUD_CNT_W-1:0] cnt_q;
    logic [BAUD_CNT_W-1:0] cnt_d;

    assign tick  = run & ~clear & (cnt_q == CNT_LAST);
    assign count = cnt_q;

    // Next counter value: hold at zero when stopped, wrap at terminal count.
    always_comb begin
        cnt_d = cnt_q;
        if (clear || !run) begin
            cnt_d = CNT_ZERO;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = CNT_ZERO;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= CNT_ZERO;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_transmitter.sv
// -----------------------------------------------------------------------------
// uart_transmitter
// Serialises bytes as: start(0), 8 data bits LSB first, optional parity
// (XOR of data), stop(1). A one-entry holding buffer lets the host queue the
// next byte while a frame is on the line; a queued byte follows with no gap.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   enable    - 0 aborts any frame and empties the buffer
//   data_in   - byte to send, captured when send & ready at a clock edge
//   send      - host valid
//   ready     - enable & buffer empty (combinational)
//   busy      - registered, high while a frame is on Tx
//   tx_done   - registered pulse in the last cycle of each stop bit
//   Tx        - registered serial line, idle high
// -----------------------------------------------------------------------------
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_RATE      = 9600,
    parameter int unsigned CLOCK_FREQ     = 50000000,
    parameter int unsigned CYCLES_PER_BIT = CLOCK_FREQ / BAUD_RATE,
    parameter int unsigned PARITY_EN      = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 send,
    output logic                 ready,
    output logic                 busy,
    output logic                 tx_done,
    output logic                 Tx
);

    if ((CYCLES_PER_BIT < 2) || (CYCLES_PER_BIT > 65535)) begin : g_bad_cycles_per_bit
        $error("uart_transmitter: CYCLES_PER_BIT must be in 2..65535");
    end

    // tx_done is registered, so it is set one cycle ahead of the last stop cycle.
    localparam logic [BAUD_CNT_W-1:0] CNT_PRE_LAST = BAUD_CNT_W'(CYCLES_PER_BIT - 2);
    localparam logic [2:0]            IDX_LAST     = 3'(DATA_BITS - 1);

    tx_state_t             state_q, state_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic [DATA_BITS-1:0]  buf_q, buf_d;
    logic                  buf_full_q, buf_full_d;
    logic                  parity_q, parity_d;
    logic [2:0]            bit_idx_q, bit_idx_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  tx_done_q, tx_done_d;

    logic                  accept;
    logic                  baud_tick;
    logic [BAUD_CNT_W-1:0] baud_count;

    assign ready   = enable & ~buf_full_q;
    assign accept  = send & ready;
    assign busy    = busy_q;
    assign tx_done = tx_done_q;
    assign Tx      = tx_q;

    uart_baud_tick #(
        .CYCLES_PER_BIT(CYCLES_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clear(~enable),
        .run  (state_q != IDLE),
        .tick (baud_tick),
        .count(baud_count)
    );

    // Frame sequencing, shifter/buffer management and next line value.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        parity_d   = parity_q;
        bit_idx_d  = bit_idx_q;
        tx_done_d  = 1'b0;

        if (!enable) begin
            state_d    = IDLE;
            bit_idx_d  = 3'd0;
            buf_full_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // A byte can sit in the buffer here if it was accepted in
                    // the final stop cycle of the previous frame.
                    if (buf_full_q) begin
                        shift_d    = buf_q;
                        parity_d   = calc_parity(buf_q);
                        buf_full_d = 1'b0;
                        bit_idx_d  = 3'd0;
                        state_d    = START;
                    end else if (accept) begin
                        shift_d   = data_in;
                        parity_d  = calc_parity(data_in);
                        bit_idx_d = 3'd0;
                        state_d   = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
                START: begin
                    if (baud_tick) begin
                        state_d = DATA;
                    end else begin
                        state_d = START;
                    end
                end
                DATA: begin
                    if (baud_tick) begin
                        shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
                        if (bit_idx_q == IDX_LAST) begin
                            bit_idx_d = 3'd0;
                            state_d   = (PARITY_EN != 0) ? PARITY : STOP;
                        end else begin
                            bit_idx_d = bit_idx_q + 3'd1;
                        end
                    end else begin
                        state_d = DATA;
                    end
                end
                PARITY: begin
                    if (baud_tick) begin
                        state_d = STOP;
                    end else begin
                        state_d = PARITY;
                    end
                end
                STOP: begin
                    tx_done_d = (baud_count == CNT_PRE_LAST);
                    if (baud_tick) begin
                        if (buf_full_q) begin
                            shift_d    = buf_q;
                            parity_d   = calc_parity(buf_q);
                            buf_full_d = 1'b0;
                            bit_idx_d  = 3'd0;
                            state_d    = START;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        state_d = STOP;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase

            // Bytes not taken straight into the shifter go to the buffer.
            if (accept && (state_q != IDLE)) begin
                buf_d      = data_in;
                buf_full_d = 1'b1;
            end else begin
                buf_d = buf_d;
            end
        end

        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = parity_d;
            STOP:    tx_d = 1'b1;
            IDLE:    tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase

        busy_d = (state_d != IDLE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= {DATA_BITS{1'b0}};
            buf_q      <= {DATA_BITS{1'b0}};
            buf_full_q <= 1'b0;
            parity_q   <= 1'b0;
            bit_idx_q  <= 3'd0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            tx_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            parity_q   <= parity_d;
            bit_idx_q  <= bit_idx_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            tx_done_q  <= tx_done_d;
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// -----------------------------------------------------------------------------
// tb_uart_transmitter
// Self-checking bench for uart_transmitter at CYCLES_PER_BIT=4, parity on.
// A line-level reference model (frame position counter plus a pending-byte
// queue) predicts Tx, busy, tx_done and ready every cycle; a separate
// mid-bit-sampling receiver model decodes frames for the loopback test.
// -----------------------------------------------------------------------------
module tb_uart_transmitter;

    localparam int CF        = 400;
    localparam int BR        = 100;
    localparam int CPB       = CF / BR;
    localparam int PE        = 1;
    localparam int FRAME_LEN = (10 + PE) * CPB;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [7:0] data_in;
    logic       send;
    logic       ready;
    logic       busy;
    logic       tx_done;
    logic       tx_line;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model state.
    bit         m_active;
    int         m_pos;
    logic [7:0] m_cur;
    logic [7:0] m_pend[$];

    uart_transmitter #(
        .BAUD_RATE (BR),
        .CLOCK_FREQ(CF),
        .PARITY_EN (PE)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .data_in(data_in),
        .send   (send),
        .ready  (ready),
        .busy   (busy),
        .tx_done(tx_done),
        .Tx     (tx_line)
    );

    always #5 clk = ~clk;

    // Line value of bit slot idx (0=start, 1..8 data, 9 parity, last stop).
    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        if (PE != 0 && idx == 9) return (($countones(b) % 2) == 1);
        return 1'b1;
    endfunction

    function automatic logic exp_tx();
        return m_active ? frame_bit(m_cur, m_pos / CPB) : 1'b1;
    endfunction

    function automatic logic exp_busy();
        return m_active;
    endfunction

    function automatic logic exp_done();
        return m_active && (m_pos == FRAME_LEN - 1);
    endfunction

    function automatic logic exp_ready();
        return (enable === 1'b1) && (m_pend.size() == 0);
    endfunction

    task automatic model_reset();
        m_active = 1'b0;
        m_pos    = 0;
        m_pend.delete();
    endtask

    // Advance the model over the coming edge, then move to the next negedge.
    task automatic step();
        bit acc;
        acc = (send === 1'b1) && exp_ready();
        if (enable !== 1'b1) begin
            m_active = 1'b0;
            m_pend.delete();
        end else if (m_active) begin
            if (m_pos == FRAME_LEN - 1) begin
                if (m_pend.size() > 0) begin
                    m_cur = m_pend.pop_front();
                    m_pos = 0;
                end else begin
                    m_active = 1'b0;
                end
            end else begin
                m_pos++;
            end
            if (acc) m_pend.push_back(data_in);
        end else if (m_pend.size() > 0) begin
            m_cur = m_pend.pop_front();
            m_active = 1'b1;
            m_pos = 0;
        end else if (acc) begin
            m_cur = data_in;
            m_active = 1'b1;
            m_pos = 0;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1; send = 1'b0; data_in = 8'h00;
        model_reset();
        #12;
        total++; if (tx_line !== 1'b1) begin bad++; $display("FAIL reset_tx got=%b want=1", tx_line); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (tx_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", tx_done); end
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", ready); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            total++;
            if (tx_line !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0 || ready !== 1'b1) begin
                bad++;
                $display("FAIL idle_outputs cyc=%0d got tx=%b busy=%b done=%b ready=%b want 1 0 0 1",
                         cyc, tx_line, busy, tx_done, ready);
            end
        end
    endtask

    task automatic test_single_frame(input logic [7:0] b);
        int done_at;
        done_at = -1;
        data_in = b; send = 1'b1;
        step();
        send = 1'b0; data_in = 8'($urandom);
        for (int k = 0; k <= FRAME_LEN; k++) begin
            total++; if (tx_line !== exp_tx()) begin bad++; $display("FAIL single_tx byte=%h k=%0d got=%b want=%b", b, k, tx_line, exp_tx()); end
            total++; if (busy !== exp_busy()) begin bad++; $display("FAIL single_busy byte=%h k=%0d got=%b want=%b", b, k, busy, exp_busy()); end
            total++; if (tx_done !== exp_done()) begin bad++; $display("FAIL single_done byte=%h k=%0d got=%b want=%b", b, k, tx_done, exp_done()); end
            total++; if (ready !== exp_ready()) begin bad++; $display("FAIL single_ready byte=%h k=%0d got=%b want=%b", b, k, ready, exp_ready()); end
            if (tx_done === 1'b1 && done_at < 0) done_at = k;
            if (k < FRAME_LEN) step();
        end
        total++;
        if (done_at != FRAME_LEN - 1) begin
            bad++;
            $display("FAIL single_done_time byte=%h got=%0d want=%0d", b, done_at, FRAME_LEN - 1);
        end
    endtask

    task automatic test_back_to_back(input logic [7:0] b0, input logic [7:0] b1);
        int pulses[$];
        data_in = b0; send = 1'b1;
        step();
        data_in = b1; send = 1'b1;
        step();
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL b2b_ready_drop got=%b want=0", ready); end
        // Third byte while the buffer is full must be ignored.
        data_in = 8'($urandom); send = 1'b1;
        step();
        send = 1'b0;
        for (int k = 2; k < 2 * FRAME_LEN + 4; k++) begin
            total++; if (tx_line !== exp_tx()) begin bad++; $display("FAIL b2b_tx k=%0d got=%b want=%b", k, tx_line, exp_tx()); end
            total++; if (busy !== exp_busy()) begin bad++; $display("FAIL b2b_busy k=%0d got=%b want=%b", k, busy, exp_busy()); end
            total++; if (tx_done !== exp_done()) begin bad++; $display("FAIL b2b_done k=%0d got=%b want=%b", k, tx_done, exp_done()); end
            total++; if (ready !== exp_ready()) begin bad++; $display("FAIL b2b_ready k=%0d got=%b want=%b", k, ready, exp_ready()); end
            if (tx_done === 1'b1) pulses.push_back(k);
            step();
        end
        total++;
        if (pulses.size() != 2) begin
            bad++; $display("FAIL b2b_pulse_count got=%0d want=2", pulses.size());
        end else begin
            total++;
            if (pulses[1] - pulses[0] != FRAME_LEN) begin
                bad++; $display("FAIL b2b_pulse_gap got=%0d want=%0d", pulses[1] - pulses[0], FRAME_LEN);
            end
        end
    endtask

    task automatic test_abort();
        data_in = 8'hFF; send = 1'b1;
        step();
        data_in = 8'h12;
        step();
        send = 1'b0;
        for (int k = 0; k < 3 * CPB; k++) step();   // into the DATA phase
        enable = 1'b0;
        step();
        total++;
        if (tx_line !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0 || ready !== 1'b0) begin
            bad++;
            $display("FAIL abort_outputs got tx=%b busy=%b done=%b ready=%b want 1 0 0 0", tx_line, busy, tx_done, ready);
        end
        send = 1'b1; data_in = 8'h99;
        step();
        send = 1'b0; enable = 1'b1;
        for (int k = 0; k < FRAME_LEN + 2; k++) begin
            step();
            total++;
            if (tx_line !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0) begin
                bad++;
                $display("FAIL abort_quiet k=%0d got tx=%b busy=%b done=%b want 1 0 0", k, tx_line, busy, tx_done);
            end
        end
        test_single_frame(8'h00);
        // Asynchronous reset in the middle of a frame.
        data_in = 8'h5A; send = 1'b1;
        step();
        send = 1'b0;
        for (int k = 0; k < 10; k++) step();
        #2 rst = 1'b1;
        #1;
        total++;
        if (tx_line !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0) begin
            bad++;
            $display("FAIL async_reset got tx=%b busy=%b done=%b want 1 0 0", tx_line, busy, tx_done);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        step();
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            send    = ($urandom_range(0, 9) < 3);
            data_in = 8'($urandom);
            enable  = ($urandom_range(0, 249) != 0);
            step();
            total++; if (tx_line !== exp_tx()) begin bad++; $display("FAIL rand_tx cyc=%0d got=%b want=%b", cyc, tx_line, exp_tx()); end
            total++; if (busy !== exp_busy()) begin bad++; $display("FAIL rand_busy cyc=%0d got=%b want=%b", cyc, busy, exp_busy()); end
            total++; if (tx_done !== exp_done()) begin bad++; $display("FAIL rand_done cyc=%0d got=%b want=%b", cyc, tx_done, exp_done()); end
            total++; if (ready !== exp_ready()) begin bad++; $display("FAIL rand_ready cyc=%0d got=%b want=%b", cyc, ready, exp_ready()); end
        end
        send = 1'b0; enable = 1'b1;
        for (int k = 0; k < 2 * FRAME_LEN + 4; k++) step();
    endtask

    // Decode each frame like a receiver sampling mid-bit.
    task automatic test_loopback();
        logic [7:0] bytes [4];
        logic       samples[$];
        logic [7:0] rx;
        logic       rx_par_err;
        int         s;
        bytes[0] = 8'h00; bytes[1] = 8'h55; bytes[2] = 8'hFF; bytes[3] = 8'h81;
        for (int n = 0; n < 4; n++) begin
            samples.delete();
            data_in = bytes[n]; send = 1'b1;
            step();
            send = 1'b0;
            for (int k = 0; k < FRAME_LEN + 2; k++) begin
                samples.push_back(tx_line);
                step();
            end
            s = -1;
            for (int k = 0; k < samples.size(); k++) begin
                if (s < 0 && samples[k] === 1'b0) s = k;
            end
            total++;
            if (s < 0 || s + FRAME_LEN > samples.size()) begin
                bad++; $display("FAIL loop_start byte=%h got=no_start want=start_bit", bytes[n]);
            end else begin
                for (int i = 0; i < 8; i++) rx[i] = samples[s + (i + 1) * CPB + CPB / 2];
                rx_par_err = (^rx) ^ samples[s + 9 * CPB + CPB / 2];
                total++; if (rx !== bytes[n]) begin bad++; $display("FAIL loop_data got=%h want=%h", rx, bytes[n]); end
                total++; if (rx_par_err !== 1'b0) begin bad++; $display("FAIL loop_parity byte=%h got=%b want=0", bytes[n], rx_par_err); end
                total++; if (samples[s + 10 * CPB + CPB / 2] !== 1'b1) begin bad++; $display("FAIL loop_stop byte=%h got=0 want=1", bytes[n]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame(8'hA5);
        for (int i = 0; i < 3; i++) test_single_frame(8'($urandom));
        test_back_to_back(8'h07, 8'h3C);
        test_back_to_back(8'($urandom), 8'($urandom));
        test_abort();
        test_random();
        test_loopback();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
